// File: rtl/axi_rd_dma.sv
// AXI4 read-DMA master: splits a descriptor into INCR bursts that stay inside 4 KB pages,
// keeps one burst in flight, and streams returned beats out through an internal FIFO.
module axi_rd_dma #(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [15:0]  cmd_beats,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  output logic [63:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  input  logic [255:0] m_axi_rdata,
  input  logic         m_axi_rlast,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [63:0]  addr_reg;
  logic [15:0]  rem_reg;
  logic [8:0]   cnt_reg;
  logic         err_reg;
  logic         done_reg;
  logic         armed_reg;
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic [256:0] fifo_mem [FIFO_DEPTH];

  logic [AW:0]  fill;
  logic [16:0]  free;
  logic [16:0]  page_room;
  logic [16:0]  want;
  logic [16:0]  len;
  logic [256:0] head;
  logic         fifo_empty;
  logic         accept;
  logic         ar_fire;
  logic         push;
  logic         pop;
  logic         final_beat;
  logic         final_pop;
  logic         unused_bits;

  assign fill       = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (fill == '0);
  assign free       = 17'(FIFO_DEPTH) - 17'(fill);
  assign page_room  = 17'd128 - {10'd0, addr_reg[11:5]};

  // want ignores FIFO room; arvalid waits until the whole of it fits, so len == want when issued
  always_comb begin
    want = {1'b0, rem_reg};
    if (want > 17'(MAX_BURST)) want = 17'(MAX_BURST);
    if (want > page_room) want = page_room;
    len = want;
    if (len > free) len = free;
  end

  assign cmd_ready     = armed_reg && (state_reg == IDLE) && fifo_empty;
  assign m_axi_arvalid = (state_reg == ADDR) && (free >= want);
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(len - 17'd1) : 8'd0;
  assign m_axi_arsize  = 3'd5;
  assign m_axi_rready  = (state_reg == DATA);

  assign accept     = cmd_valid && cmd_ready;
  assign ar_fire    = m_axi_arvalid && m_axi_arready;
  assign push       = m_axi_rvalid && m_axi_rready;
  assign final_beat = (rem_reg == 16'd0) && (cnt_reg == 9'd1);

  assign head      = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[255:0] : 256'd0;
  assign out_last  = out_valid && head[256];
  assign pop       = out_valid && out_ready;
  assign final_pop = pop && out_last;

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign err  = err_reg;

  assign unused_bits = ^{cmd_addr[4:0], len[16:9]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && cmd_beats != 16'd0) state_next = ADDR;
      ADDR:    if (ar_fire) state_next = DATA;
      DATA:    if (push && cnt_reg == 9'd1) state_next = (rem_reg == 16'd0) ? DRAIN : ADDR;
      DRAIN:   if (final_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      armed_reg  <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      done_reg  <= (accept && cmd_beats == 16'd0) || ((state_reg == DRAIN) && final_pop);
      if (accept) begin
        addr_reg <= {cmd_addr[63:5], 5'd0};
        rem_reg  <= cmd_beats;
        err_reg  <= 1'b0;
      end
      if (ar_fire) begin
        addr_reg <= addr_reg + {50'd0, len[8:0], 5'd0};
        rem_reg  <= rem_reg - {7'd0, len[8:0]};
        cnt_reg  <= len[8:0];
      end
      // the burst is closed by the beat count; rlast is only checked against it
      if (push) begin
        cnt_reg    <= cnt_reg - 9'd1;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (m_axi_rlast != (cnt_reg == 9'd1)) err_reg <= 1'b1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {final_beat, m_axi_rdata};
  end

endmodule
